// File: rtl/alu_result_stage_if.sv
// Handshake bundle for the EX->MEM result stage: the ALU-side input and MEM-side output.
// The stage itself uses the slave modport; whatever drives it uses master.
interface alu_result_stage_if #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_result;
    logic               in_ovf;
    logic               in_ovf_en;
    logic [DATA_W-1:0]  in_store;
    logic [RADDR_W-1:0] in_waddr;
    logic [2:0]         in_ctrl;
    logic [PC_W-1:0]    in_pc;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_result;
    logic [DATA_W-1:0]  out_store;
    logic [RADDR_W-1:0] out_waddr;
    logic [2:0]         out_ctrl;
    logic [PC_W-1:0]    out_pc;
    logic               exc_req;
    logic [PC_W-1:0]    exc_epc;

    modport slave (
        input  in_valid, in_result, in_ovf, in_ovf_en, in_store, in_waddr, in_ctrl, in_pc,
        output in_ready,
        output out_valid, out_result, out_store, out_waddr, out_ctrl, out_pc, exc_req, exc_epc,
        input  out_ready
    );

    modport master (
        output in_valid, in_result, in_ovf, in_ovf_en, in_store, in_waddr, in_ctrl, in_pc,
        input  in_ready,
        input  out_valid, out_result, out_store, out_waddr, out_ctrl, out_pc, exc_req, exc_epc,
        output out_ready
    );
endinterface

// File: rtl/alu_result_stage.sv
// EX->MEM register stage with a main+skid buffer so in_ready is registered, and
// precise overflow traps that kill the trapping entry's side effects and squash younger ones.
module alu_result_stage #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    alu_result_stage_if.slave  bus
);
    typedef struct packed {
        logic               exc;
        logic [2:0]         ctrl;
        logic [RADDR_W-1:0] waddr;
        logic [PC_W-1:0]    pc;
        logic [DATA_W-1:0]  store;
        logic [DATA_W-1:0]  result;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   exc_pending;
    logic   trap;
    logic   acc_in;
    logic   acc_out;
    logic   keep_in;
    logic   exc_req;

    // A trapping entry keeps its PC for the EPC but loses reg/mem write enables.
    always_comb begin
        in_entry        = '0;
        trap            = bus.in_ovf & bus.in_ovf_en;
        in_entry.exc    = trap;
        in_entry.ctrl   = trap ? 3'b000 : bus.in_ctrl;
        in_entry.waddr  = bus.in_waddr;
        in_entry.pc     = bus.in_pc;
        in_entry.store  = bus.in_store;
        in_entry.result = bus.in_result;
    end

    assign acc_in  = bus.in_valid & ~skid_valid;
    assign acc_out = main_valid & bus.out_ready;
    assign keep_in = acc_in & ~exc_pending;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            exc_pending <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            if (acc_in && trap) begin
                exc_pending <= 1'b1;
            end
            if (!main_valid) begin
                if (keep_in) begin
                    main_q     <= in_entry;
                    main_valid <= 1'b1;
                end
            end else if (acc_out) begin
                // skid is always older than anything arriving this cycle
                if (skid_valid) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else if (keep_in) begin
                    main_q <= in_entry;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (keep_in) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end
    end

    assign exc_req        = main_valid & main_q.exc;
    assign bus.in_ready   = ~skid_valid;
    assign bus.out_valid  = main_valid;
    assign bus.out_result = main_q.result;
    assign bus.out_store  = main_q.store;
    assign bus.out_waddr  = main_q.waddr;
    assign bus.out_ctrl   = main_q.ctrl;
    assign bus.out_pc     = main_q.pc;
    assign bus.exc_req    = exc_req;
    assign bus.exc_epc    = exc_req ? main_q.pc : '0;
endmodule

// File: tb/tb_alu_result_stage.sv
// Table-driven bench for alu_result_stage with a queue scoreboard of expected entries
// plus hand-written stall, trap, flush and reset sequences.
module tb_alu_result_stage;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 32;
    localparam int RADDR_W = 5;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        ovf_en;
        logic [2:0]  ctrl;
        logic [31:0] pc;
        logic [2:0]  exp_ctrl;
        logic        exp_exc;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  waddr;
        logic [2:0]  ctrl;
        logic [31:0] pc;
        logic        exc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    alu_result_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W), .RADDR_W(RADDR_W)) bus ();

    alu_result_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .RADDR_W(RADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    exp_t sb[$];
    vec_t cur;
    vec_t vecs[6];
    bit   model_pending;
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(logic [31:0] result, logic ovf, logic ovf_en, logic [2:0] ctrl,
                                logic [31:0] pc, logic [2:0] exp_ctrl, logic exp_exc);
        vec_t v;
        v.result   = result;
        v.ovf      = ovf;
        v.ovf_en   = ovf_en;
        v.ctrl     = ctrl;
        v.pc       = pc;
        v.exp_ctrl = exp_ctrl;
        v.exp_exc  = exp_exc;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit valid);
        cur           = v;
        bus.in_valid  = valid;
        bus.in_result = v.result;
        bus.in_ovf    = v.ovf;
        bus.in_ovf_en = v.ovf_en;
        bus.in_store  = ~v.result;
        bus.in_waddr  = v.result[4:0];
        bus.in_ctrl   = v.ctrl;
        bus.in_pc     = v.pc;
    endtask

    // Anything leaving the stage this cycle must be the oldest expected entry.
    task automatic checkOutput();
        exp_t e;
        if (!reset && !flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("[TB] FAIL unexpected_output: got pc 0x%08h, want no entry", bus.out_pc);
            end else begin
                e = sb.pop_front();
                compare("out_result", bus.out_result, e.result);
                compare("out_store", bus.out_store, e.store);
                compare("out_waddr", 32'(bus.out_waddr), 32'(e.waddr));
                compare("out_ctrl", 32'(bus.out_ctrl), 32'(e.ctrl));
                compare("out_pc", bus.out_pc, e.pc);
                compare("exc_req", 32'(bus.exc_req), 32'(e.exc));
                compare("exc_epc", bus.exc_epc, e.exc ? e.pc : 32'h0);
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        checkOutput();
        if (reset || flush) begin
            sb.delete();
            model_pending = 1'b0;
        end else if (bus.in_valid && bus.in_ready && !model_pending) begin
            e.result = cur.result;
            e.store  = ~cur.result;
            e.waddr  = cur.result[4:0];
            e.ctrl   = cur.exp_ctrl;
            e.pc     = cur.pc;
            e.exc    = cur.exp_exc;
            sb.push_back(e);
            if (cur.ovf && cur.ovf_en) model_pending = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
        compare("drain_left", 32'(sb.size()), 32'h0);
        compare("drain_out_valid", 32'(bus.out_valid), 32'h0);
    endtask

    task automatic checkCleared(input string tag);
        compare({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        compare({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
        compare({tag, "_exc_req"}, 32'(bus.exc_req), 32'h0);
        compare({tag, "_exc_epc"}, bus.exc_epc, 32'h0);
        compare({tag, "_out_result"}, bus.out_result, 32'h0);
        compare({tag, "_out_ctrl"}, 32'(bus.out_ctrl), 32'h0);
        compare({tag, "_out_pc"}, bus.out_pc, 32'h0);
    endtask

    initial begin
        vec_t a, b, c, t, x;
        n_vec         = 0;
        n_bad         = 0;
        model_pending = 1'b0;

        vecs[0] = mk(32'h0000_0011, 1'b0, 1'b1, 3'b100, 32'h0040_0000, 3'b100, 1'b0);
        vecs[1] = mk(32'hFFFF_FFFE, 1'b0, 1'b1, 3'b001, 32'h0040_0004, 3'b001, 1'b0);
        vecs[2] = mk(32'h7FFF_FFFF, 1'b0, 1'b0, 3'b010, 32'h0040_0008, 3'b010, 1'b0);
        vecs[3] = mk(32'h1234_5678, 1'b0, 1'b1, 3'b100, 32'h0040_000C, 3'b100, 1'b0);
        vecs[4] = mk(32'h8000_0001, 1'b1, 1'b0, 3'b100, 32'h0040_0014, 3'b100, 1'b0);
        vecs[5] = mk(32'hDEAD_BEEF, 1'b1, 1'b0, 3'b110, 32'h0040_0018, 3'b110, 1'b0);

        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(mk(32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 3'b000, 1'b0), 1'b0);
        @(negedge clk);
        cycle();
        cycle();
        checkCleared("reset");
        reset = 1'b0;

        // Back-to-back stream with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], 1'b1);
            compare("stream_in_ready", 32'(bus.in_ready), 32'h1);
            if (i > 0) compare("stream_out_valid", 32'(bus.out_valid), 32'h1);
            cycle();
        end
        drain();

        // Stall: main then skid fill, in_ready drops, then both drain in order
        a = mk(32'hA000_0001, 1'b0, 1'b1, 3'b100, 32'h0040_0100, 3'b100, 1'b0);
        b = mk(32'hB000_0002, 1'b0, 1'b1, 3'b001, 32'h0040_0104, 3'b001, 1'b0);
        c = mk(32'hC000_0003, 1'b1, 1'b0, 3'b010, 32'h0040_0108, 3'b010, 1'b0);
        bus.out_ready = 1'b0;
        applyStimulus(a, 1'b1);
        compare("stall_in_ready0", 32'(bus.in_ready), 32'h1);
        cycle();
        applyStimulus(b, 1'b1);
        compare("stall_in_ready1", 32'(bus.in_ready), 32'h1);
        compare("stall_out_valid", 32'(bus.out_valid), 32'h1);
        cycle();
        applyStimulus(c, 1'b1);
        compare("stall_in_ready2", 32'(bus.in_ready), 32'h0);
        cycle();
        compare("stall_in_ready3", 32'(bus.in_ready), 32'h0);
        compare("stall_out_pc_hold", bus.out_pc, a.pc);
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        compare("release_in_ready", 32'(bus.in_ready), 32'h1);
        cycle();
        drain();

        // Overflow trap: killed ctrl, EPC held while stalled, younger inputs squashed
        t = mk(32'h8000_0000, 1'b1, 1'b1, 3'b100, 32'h0040_0010, 3'b000, 1'b1);
        bus.out_ready = 1'b0;
        applyStimulus(t, 1'b1);
        cycle();
        compare("trap_exc_req", 32'(bus.exc_req), 32'h1);
        compare("trap_exc_epc", bus.exc_epc, 32'h0040_0010);
        compare("trap_out_ctrl", 32'(bus.out_ctrl), 32'h0);
        compare("trap_out_result", bus.out_result, 32'h8000_0000);
        applyStimulus(a, 1'b1);
        compare("trap_in_ready1", 32'(bus.in_ready), 32'h1);
        cycle();
        applyStimulus(b, 1'b1);
        compare("trap_in_ready2", 32'(bus.in_ready), 32'h1);
        compare("trap_exc_held", 32'(bus.exc_req), 32'h1);
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        compare("squash_out_valid0", 32'(bus.out_valid), 32'h0);
        cycle();
        compare("squash_out_valid1", 32'(bus.out_valid), 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        compare("post_trap_flush_valid", 32'(bus.out_valid), 32'h0);
        applyStimulus(c, 1'b1);
        cycle();
        drain();

        // Flush with main+skid full and an input waiting
        bus.out_ready = 1'b0;
        applyStimulus(a, 1'b1);
        cycle();
        applyStimulus(b, 1'b1);
        cycle();
        applyStimulus(c, 1'b1);
        compare("flush_full_in_ready", 32'(bus.in_ready), 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checkCleared("flush_full");
        // Flush while in_ready=1: the flush-cycle input must not be kept
        applyStimulus(a, 1'b1);
        cycle();
        applyStimulus(b, 1'b1);
        compare("flush_half_in_ready", 32'(bus.in_ready), 32'h1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        compare("flush_half_valid0", 32'(bus.out_valid), 32'h0);
        cycle();
        compare("flush_half_valid1", 32'(bus.out_valid), 32'h0);
        drain();

        // Reset mid-stall with a trap sitting in the skid entry
        x = mk(32'h0000_0055, 1'b0, 1'b0, 3'b100, 32'h0040_0200, 3'b100, 1'b0);
        bus.out_ready = 1'b0;
        applyStimulus(a, 1'b1);
        cycle();
        applyStimulus(t, 1'b1);
        cycle();
        applyStimulus(x, 1'b1);
        compare("rst_stall_in_ready", 32'(bus.in_ready), 32'h0);
        reset = 1'b1;
        cycle();
        checkCleared("mid_reset");
        reset        = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(x, 1'b1);
        cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
